buf_stream_reader: RTL and testbench

BUF_STREAM_READER -- requirements
Module: buf_stream_reader

---
 rtl/buf_stream_reader.sv | 136 +++++++++++++
 tb/tb_buf_stream_reader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/buf_stream_reader.sv
// Streams a block of words out of a 1-cycle-latency buffer RAM onto a valid/ready stream.
// Reads are credit-limited against a 2-entry output FIFO so backpressure never drops data.
module buf_stream_reader #(
   parameter int unsigned AW = 7,
   parameter int unsigned DW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [AW-1:0]   base,
   input  logic [AW:0]     len,
   output logic            busy,
   output logic            done,
   output logic [AW-1:0]   ram_addr,
   output logic [DW/8-1:0] ram_we,
   input  logic [DW-1:0]   ram_dout,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [DW-1:0]   m_data,
   output logic            m_last
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   localparam logic [AW:0] LenOne = 1;

   state_e          state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic [AW-1:0]   addr_q;
   logic [AW:0]     left_q, left_d;
   logic            rd_q, rd_last_q;
   logic [DW-1:0]   data_q [2];
   logic [DW-1:0]   data_d [2];
   logic [1:0]      last_q, last_d;
   logic [1:0]      cnt_q, cnt_d;
   logic            done_q, done_d;
   logic            pop, push, issue, issue_last, wr_idx;
   logic [2:0]      occ;

   // Credit: entries left after this cycle's pop plus the read whose data lands this cycle.
   always_comb begin
      pop        = (cnt_q != 2'd0) && m_ready;
      push       = rd_q;
      occ        = {1'b0, cnt_q} + {2'b0, rd_q} - {2'b0, pop};
      issue      = (state_q == StRun) && (occ < 3'd2);
      issue_last = issue && (left_q == LenOne);
      ram_addr   = issue ? ptr_q : addr_q;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      left_d  = left_q;
      done_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               if (len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = StRun;
                  ptr_d   = base;
                  left_d  = len;
               end
            end
         end
         StRun: begin
            if (issue) begin
               ptr_d  = ptr_q + AW'(1);
               left_d = left_q - LenOne;
               if (left_q == LenOne) state_d = StDrain;
            end
         end
         StDrain: begin
            if (pop && last_q[0]) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Shift-register FIFO: entry 0 is always the head.
   always_comb begin
      data_d = data_q;
      last_d = last_q;
      cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
      wr_idx = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && !pop);
      if (pop) begin
         data_d[0] = data_q[1];
         last_d[0] = last_q[1];
      end
      if (push) begin
         data_d[wr_idx] = ram_dout;
         last_d[wr_idx] = rd_last_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         addr_q    <= '0;
         left_q    <= '0;
         rd_q      <= 1'b0;
         rd_last_q <= 1'b0;
         data_q[0] <= '0;
         data_q[1] <= '0;
         last_q    <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         left_q    <= left_d;
         if (issue) addr_q <= ptr_q;
         rd_q      <= issue;
         rd_last_q <= issue_last;
         data_q    <= data_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      busy    = (state_q != StIdle);
      done    = done_q;
      m_valid = (cnt_q != 2'd0);
      m_data  = data_q[0];
      m_last  = m_valid && last_q[0];
      ram_we  = '0;
   end

endmodule

// File: tb/tb_buf_stream_reader.sv
// Scoreboard bench for buf_stream_reader: a monitor predicts stream words, done and busy
// from accepted starts; directed tasks add latency, wrap, zero-length, reset and restart cases.
module tb_buf_stream_reader;

   localparam int AW = 7;
   localparam int DW = 32;

   logic            clk, rst, start;
   logic [AW-1:0]   base;
   logic [AW:0]     len;
   logic            busy, done;
   logic [AW-1:0]   ram_addr;
   logic [DW/8-1:0] ram_we;
   logic [DW-1:0]   ram_dout;
   logic            m_valid, m_ready;
   logic [DW-1:0]   m_data;
   logic            m_last;

   logic [DW-1:0] mem [128];
   int            n_checks, n_errors, hs_count;
   bit            rand_ready;
   logic          done_exp, busy_m;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;
   exp_t sb[$];

   buf_stream_reader #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
      .busy(busy), .done(done), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_dout(ram_dout), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_last(m_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) ram_dout <= mem[ram_addr];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor: compares head word, done and busy, then advances the model.
   always @(negedge clk) begin : mon
      logic          busy_now;
      exp_t          e;
      logic [AW-1:0] a;
      busy_now = busy_m;
      if (m_valid) begin
         if (sb.size() == 0) begin
            check_eq("spurious_valid", 64'(m_valid), 64'd0);
         end else begin
            check_eq("m_data", 64'(m_data), 64'(sb[0].data));
            check_eq("m_last", 64'(m_last), 64'(sb[0].last));
         end
      end
      check_eq("done", 64'(done), 64'(done_exp));
      check_eq("busy", 64'(busy), 64'(busy_m));
      check_eq("ram_we", 64'(ram_we), 64'd0);
      if (rst) begin
         sb.delete();
         done_exp = 1'b0;
         busy_m   = 1'b0;
      end else begin
         done_exp = 1'b0;
         if (m_valid && m_ready && sb.size() > 0) begin
            hs_count++;
            if (sb[0].last) begin
               done_exp = 1'b1;
               busy_m   = 1'b0;
            end
            void'(sb.pop_front());
         end
         if (start && !busy_now) begin
            if (len == '0) begin
               done_exp = 1'b1;
            end else begin
               busy_m = 1'b1;
               for (int i = 0; i < int'(len); i++) begin
                  a      = base + AW'(i);
                  e.data = {{(DW-AW){1'b0}}, a};
                  e.last = (i == int'(len) - 1);
                  sb.push_back(e);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic start_xfer(input logic [AW-1:0] b, input logic [AW:0] l);
      base  = b;
      len   = l;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 600; i++) begin
         if (!busy && !done && sb.size() == 0) break;
         tick();
      end
      if (i == 600) check_eq("idle_timeout", {61'd0, busy, done, sb.size() != 0}, 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = DW'(i);
      n_checks   = 0;
      n_errors   = 0;
      hs_count   = 0;
      done_exp   = 1'b0;
      busy_m     = 1'b0;
      rand_ready = 1'b0;
      rst        = 1'b1;
      start      = 1'b0;
      base       = '0;
      len        = '0;
      m_ready    = 1'b1;
      repeat (2) tick();
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_valid", 64'(m_valid), 64'd0);
      check_eq("rst_last", 64'(m_last), 64'd0);
      check_eq("rst_data", 64'(m_data), 64'd0);
      check_eq("rst_addr", 64'(ram_addr), 64'd0);
      rst = 1'b0;
      tick();

      // Basic transfer: latency, back-to-back words, done timing
      start_xfer(7'h10, 8'd4);
      check_eq("valid_c1", 64'(m_valid), 64'd0);
      tick();
      check_eq("valid_c2", 64'(m_valid), 64'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         check_eq("b2b_valid", 64'(m_valid), 64'd1);
         check_eq("b2b_data", 64'(m_data), 64'(32'h10 + i));
         tick();
      end
      check_eq("done_c7", 64'(done), 64'd1);
      check_eq("busy_c7", 64'(busy), 64'd0);
      wait_idle();

      // Address wrap
      start_xfer(7'h7E, 8'd4);
      for (int i = 0; i < 4; i++) begin
         check_eq("wrap_addr", 64'(ram_addr), 64'(7'(7'h7E + i)));
         tick();
      end
      wait_idle();

      // Random backpressure
      hs_count   = 0;
      rand_ready = 1'b1;
      start_xfer(7'h30, 8'd8);
      wait_idle();
      rand_ready = 1'b0;
      m_ready    = 1'b1;
      check_eq("stall_count", 64'(hs_count), 64'd8);
      tick();

      // Zero length
      start_xfer(7'h05, 8'd0);
      check_eq("zero_done", 64'(done), 64'd1);
      check_eq("zero_busy", 64'(busy), 64'd0);
      check_eq("zero_valid", 64'(m_valid), 64'd0);
      tick();
      check_eq("zero_valid2", 64'(m_valid), 64'd0);
      check_eq("zero_busy2", 64'(busy), 64'd0);
      wait_idle();

      // Reset mid-transfer
      hs_count = 0;
      start_xfer(7'h00, 8'd128);
      for (int i = 0; i < 200; i++) begin
         if (hs_count >= 5) break;
         tick();
      end
      check_eq("hs_reached", 64'(hs_count >= 5), 64'd1);
      rst = 1'b1;
      tick();
      check_eq("mrst_busy", 64'(busy), 64'd0);
      check_eq("mrst_done", 64'(done), 64'd0);
      check_eq("mrst_valid", 64'(m_valid), 64'd0);
      check_eq("mrst_last", 64'(m_last), 64'd0);
      check_eq("mrst_data", 64'(m_data), 64'd0);
      check_eq("mrst_addr", 64'(ram_addr), 64'd0);
      rst = 1'b0;
      tick();
      hs_count = 0;
      start_xfer(7'h00, 8'd2);
      wait_idle();
      check_eq("post_rst_count", 64'(hs_count), 64'd2);

      // Start while busy is ignored; start in done cycle is accepted
      hs_count = 0;
      start_xfer(7'h20, 8'd3);
      start_xfer(7'h40, 8'd2);
      for (int i = 0; i < 50; i++) begin
         if (done) break;
         tick();
      end
      check_eq("done_seen", 64'(done), 64'd1);
      start_xfer(7'h50, 8'd2);
      check_eq("restart_busy", 64'(busy), 64'd1);
      wait_idle();
      check_eq("restart_count", 64'(hs_count), 64'd5);

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
